// File: rtl/serial_8_deserializer.sv
// Serial-to-parallel word assembler with held valid/ready output and sticky overrun/framing flags.
// Word visible the cycle after its last bit is sampled; a word completing while the output is stalled is dropped.
module serial_8_deserializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             en,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, first_word, shifted;
  logic [CW-1:0]    bit_cnt, cnt_nx;
  logic             word_done, frame_evt, load;

  always_comb begin
    if (MSB_FIRST) begin
      first_word = {{(WIDTH-1){1'b0}}, serial_in};
      shifted    = {shreg[WIDTH-2:0], serial_in};
    end else begin
      first_word = {serial_in, {(WIDTH-1){1'b0}}};
      shifted    = {serial_in, shreg[WIDTH-1:1]};
    end
  end

  // A frame_start mid-word realigns immediately, even on what would have been the last bit.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    cnt_nx    = bit_cnt;
    word_done = 1'b0;
    frame_evt = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            shreg_nx = first_word;
            cnt_nx   = CW'(1);
            state_nx = SHIFT;
          end
        end
        SHIFT: begin
          if (frame_start) begin
            frame_evt = (bit_cnt != '0);
            shreg_nx  = first_word;
            cnt_nx    = CW'(1);
          end else if (bit_cnt == LAST) begin
            shreg_nx  = shifted;
            word_done = 1'b1;
            cnt_nx    = '0;
            if (!CONTINUOUS) state_nx = IDLE;
          end else begin
            shreg_nx = shifted;
            cnt_nx   = bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign load = word_done && (!out_valid || out_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= cnt_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (load) begin
        parallel_out <= shreg_nx;
        out_valid    <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (word_done && !load) overrun <= 1'b1;
      else if (clear_flags)   overrun <= 1'b0;
      if (frame_evt)          frame_err <= 1'b1;
      else if (clear_flags)   frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_8_deserializer.sv
// Bench for serial_8_deserializer: MSB-first and LSB-first instances on shared stimulus, table-driven words plus a word scoreboard.
module tb_serial_8_deserializer;

  logic       clock = 1'b0;
  logic       reset_n, serial_in, en, frame_start, out_ready, clear_flags;
  logic [7:0] po_m, po_l;
  logic       vld_m, ovr_m, ferr_m, vld_l, ovr_l, ferr_l;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] sb_exp;

  typedef struct {
    logic [7:0] word;
    int         nbits;
    logic       fs;
    logic       rdy;
    logic       gap;
    logic       load;
    logic       clr;
    logic [7:0] exp_out;
    logic       exp_vld;
    logic       exp_ovr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  serial_8_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1)) dut_msb (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in), .en(en),
    .frame_start(frame_start), .out_ready(out_ready), .clear_flags(clear_flags),
    .parallel_out(po_m), .out_valid(vld_m), .overrun(ovr_m), .frame_err(ferr_m));

  serial_8_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CONTINUOUS(1'b1)) dut_lsb (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in), .en(en),
    .frame_start(frame_start), .out_ready(out_ready), .clear_flags(clear_flags),
    .parallel_out(po_l), .out_valid(vld_l), .overrun(ovr_l), .frame_err(ferr_l));

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Drive at posedge+1, let one rising edge consume the inputs, return at posedge+1.
  task automatic step(input logic s, input logic f, input logic e, input logic r, input logic c);
    serial_in   = s;
    frame_start = f;
    en          = e;
    out_ready   = r;
    clear_flags = c;
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  // Inputs are stable at the negedge, so a valid&&ready seen here is accepted on the next rising edge.
  always @(negedge clock) begin
    if (reset_n && vld_m && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %02h expected no word", po_m);
      end else begin
        sb_exp = sb.pop_front();
        chk8("sb_word", po_m, sb_exp);
      end
    end
  end

  initial begin
    reset_n = 1'b0; serial_in = 1'b0; en = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; clear_flags = 1'b0;

    //          word   n  fs    rdy   gap   load  clr   out    vld   ovr   ferr
    vecs[0] = '{8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hC3, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h12, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hE0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'hF0, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    chk8("rst_out_m", po_m, 8'h00);   chk1("rst_vld_m", vld_m, 1'b0);
    chk1("rst_ovr_m", ovr_m, 1'b0);   chk1("rst_ferr_m", ferr_m, 1'b0);
    chk8("rst_out_l", po_l, 8'h00);   chk1("rst_vld_l", vld_l, 1'b0);
    chk1("rst_ovr_l", ovr_l, 1'b0);   chk1("rst_ferr_l", ferr_l, 1'b0);
    reset_n = 1'b1;

    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("idle_ignore_vld", vld_m, 1'b0);

    for (int k = 0; k < 8; k++) begin
      if (vecs[k].load) sb.push_back(vecs[k].word);
      for (int i = 0; i < vecs[k].nbits; i++) begin
        if (vecs[k].gap && i > 0)
          step(1'($urandom), 1'($urandom), 1'b0, vecs[k].rdy, 1'b0);
        step(vecs[k].word[7-i], vecs[k].fs && (i == 0), 1'b1, vecs[k].rdy, 1'b0);
        if (vecs[k].rdy && i == vecs[k].nbits - 2)
          chk1($sformatf("v%0d_pre_vld", k), vld_m, 1'b0);
      end
      chk8($sformatf("v%0d_out", k), po_m, vecs[k].exp_out);
      chk1($sformatf("v%0d_vld", k), vld_m, vecs[k].exp_vld);
      chk1($sformatf("v%0d_ovr", k), ovr_m, vecs[k].exp_ovr);
      chk1($sformatf("v%0d_ferr", k), ferr_m, vecs[k].exp_ferr);
      if (!vecs[k].rdy) begin
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk8($sformatf("v%0d_hold_out", k), po_m, vecs[k].exp_out);
        chk1($sformatf("v%0d_hold_vld", k), vld_m, 1'b1);
      end
      if (vecs[k].clr) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk1($sformatf("v%0d_clr_ovr", k), ovr_m, 1'b0);
      end
    end

    // Clear, then a framing error coinciding with clear_flags must leave the flag set.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk1("clr_ferr", ferr_m, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b1, 1'b0);
    chk1("mid_word_vld", vld_m, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk1("set_wins_ferr", ferr_m, 1'b1);

    // Asynchronous reset in the middle of a word.
    reset_n = 1'b0;
    #1;
    chk8("mrst_out_m", po_m, 8'h00);  chk1("mrst_vld_m", vld_m, 1'b0);
    chk1("mrst_ferr_m", ferr_m, 1'b0);
    chk8("mrst_out_l", po_l, 8'h00);  chk1("mrst_vld_l", vld_l, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("post_rst_idle_vld", vld_m, 1'b0);

    sb.push_back(8'hA0);
    for (int i = 0; i < 8; i++) step(i == 0 || i == 2, i == 0, 1'b1, 1'b0, 1'b0);
    chk8("lsb_out", po_l, 8'h05);
    chk1("lsb_vld", vld_l, 1'b1);
    chk8("msb_out", po_m, 8'hA0);
    chk1("msb_vld", vld_m, 1'b1);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("drain_vld", vld_m, 1'b0);
    chk1("sb_empty", sb.size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
